uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART serial receiver; the receive-side counterpart of the team's UART transmitter.
//  Frame format: 1 start bit (0), size+1 data bits LSB first, 1 stop bit (1); no parity.
//  Synchronises the asynchronous i_rx line and samples each bit at mid-bit from its own bit counter.
//  Presents each received word with a one-cycle valid strobe to downstream logic.
// PARAMETERS
//  size          7   data MSB index; word width = size+1
//  CLKS_PER_BIT  16  i_clk cycles per bit; >= 4; odd values allowed (half-bit = floor(CLKS_PER_BIT/2))
// PORTS
//  i_clk        in   1       clock; all logic on rising edge
//  i_rst_n      in   1       reset; synchronous, active-low
//  i_rx         in   1       serial line; asynchronous to i_clk; idles high
//  O_Data       out  size+1  last correctly framed word; holds until the next good frame
//  O_Valid      out  1       1-cycle pulse: O_Data updated this cycle
//  O_Err        out  1       1-cycle pulse: stop bit sampled 0 (framing error)
//  O_Busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (i_rst_n=0 at a clock edge), any time including mid-frame:
//   state=IDLE; bit counter, cycle counter, shift register = 0; both sync flops = 1.
//   O_Data=0, O_Valid=0, O_Err=0, O_Busy=0. Any partial frame is discarded.
//  Synchroniser: i_rx -> 2 flops -> rx_s. Adds 2 cycles of latency. The FSM uses only rx_s.
//  Cycle counter width = $clog2(CLKS_PER_BIT). It clears on every state transition.
//  FSM:
//   IDLE  : rx_s==0 -> START.
//   START : count to CLKS_PER_BIT/2-1 (mid start bit).
//           rx_s==0 there -> DATA.
//           rx_s==1 there -> IDLE (glitch rejected; no strobe).
//   DATA  : each bit lasts CLKS_PER_BIT cycles; sample rx_s when the counter = CLKS_PER_BIT-1.
//           Shift right: the new bit enters the MSB, so the first (LSB) bit lands at bit 0 after size+1 bits.
//           After bit size is sampled -> STOP.
//   STOP  : sample rx_s when the counter = CLKS_PER_BIT-1.
//           rx_s==1: O_Data <= shift reg, O_Valid=1 for one cycle, -> IDLE.
//           rx_s==0: O_Err=1 for one cycle, O_Data unchanged, -> BREAK.
//   BREAK : wait for rx_s==1, then -> IDLE. A held-low line (break) never re-triggers START.
//  The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with exactly one stop bit are received.
//  O_Valid and O_Err are never high in the same cycle. Both are registered outputs.
//  No back-pressure: a new word overwrites O_Data; the consumer must take it on O_Valid.
//  Latency: O_Valid asserts L = 2 + CLKS_PER_BIT/2 + (size+2)*CLKS_PER_BIT cycles after the first
//   clock edge that sees i_rx=0. The bench allows +-1 cycle.
//   Default L = 154.
//  i_rx activity outside IDLE that is not at a sample point has no effect.
// TESTING (CLKS_PER_BIT=16, size=7 unless stated; bit period = 16 cycles)
//  1. Send 0xA5 -> exactly one O_Valid pulse at 154+-1 cycles; O_Data=8'hA5; O_Err=0.
//     O_Busy is high throughout and low one cycle after the pulse.
//  2. Drive i_rx low for 4 cycles, then high -> O_Busy pulses briefly, no O_Valid/O_Err.
//     The FSM is back in IDLE; a following 0x3C frame is received correctly.
//  3. Send 0x11, then a frame with stop bit 0 and data 0x77 -> O_Err pulses once and O_Data stays 8'h11.
//     Hold i_rx low 200 cycles -> no further strobes.
//     Release the line, then send 0x3C -> O_Valid, O_Data=8'h3C.
//  4. Back-to-back 0x00, 0xFF, 0x80 with one stop bit each -> three O_Valid pulses 160 cycles apart.
//     Data values are correct; O_Err never asserts.
//  5. Assert i_rst_n=0 for 1 cycle during data bit 3 of 0xC3 -> next cycle all outputs 0.
//     No O_Valid for the aborted frame; a following 0x5A is received as 8'h5A.
//  6. CLKS_PER_BIT=5, size=4: send 5'b10011 -> O_Valid, O_Data=5'h13.
//     Also with a +-1-cycle skew per bit period -> still correct.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-flop line sync, mid-bit sampling, 1-cycle valid/error strobes
module uart_rx #(
  parameter int size         = 7,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx,
  output logic [size:0] O_Data,
  output logic          O_Valid,
  output logic          O_Err,
  output logic          O_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (size > 0) ? $clog2(size + 1) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(size);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [size:0] r_shift;
  logic [size:0] r_data;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_valid;
  logic          r_err;
  logic          w_rx_s;

  assign w_rx_s  = r_sync2;
  assign O_Data  = r_data;
  assign O_Valid = r_valid;
  assign O_Err   = r_err;
  assign O_Busy  = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          // A start bit that is gone by mid-bit was a glitch
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[size:1]};
            if (r_bit == BIT_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must go high before a new start bit is accepted
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx (16 clk/bit x 8 bits, plus 5 clk/bit x 5 bits)
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_e;
    logic [7:0] exp_d;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx5 = 1'b1;
  logic [7:0] data;
  logic       valid, err, busy;
  logic [4:0] data5;
  logic       valid5, err5, busy5;

  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;
  int v_cnt = 0, e_cnt = 0, both_cnt = 0, v_last = 0;
  int v5_cnt = 0, e5_cnt = 0, v5_last = 0;
  int v_cycs[$];
  int v_datas[$];
  bit busy_hist[int];
  int t_start = 0;
  vec_t vecs[10];

  uart_rx #(.size(7), .CLKS_PER_BIT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx),
    .O_Data(data), .O_Valid(valid), .O_Err(err), .O_Busy(busy)
  );

  uart_rx #(.size(4), .CLKS_PER_BIT(5)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx5),
    .O_Data(data5), .O_Valid(valid5), .O_Err(err5), .O_Busy(busy5)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_hist[cyc] = busy;
    if (valid) begin
      v_cnt++;
      v_last = cyc;
      v_cycs.push_back(cyc);
      v_datas.push_back(int'(data));
    end
    if (err) e_cnt++;
    if (valid && err) both_cnt++;
    if (valid5) begin
      v5_cnt++;
      v5_last = cyc;
    end
    if (err5) e5_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx = b;
    else rx5 = b;
  endtask

  task automatic idle(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // skew != 0 alternates bit lengths cpb+skew, cpb-skew, ... starting at the start bit
  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop,
                            input int nbits, input int cpb, input int skew);
    logic b;
    int len;
    for (int i = 0; i < nbits + 2; i++) begin
      if (i == 0) b = 1'b0;
      else if (i <= nbits) b = d[i-1];
      else b = stop;
      if (i == 0) t_start = cyc + 1;
      len = cpb + ((i % 2 == 0) ? skew : -skew);
      set_line(sel, b);
      repeat (len) @(negedge clk);
    end
  endtask

  initial begin
    int v0, e0, lows, highs, lat, qi;
    vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
    vecs[2] = '{8'h11, 1'b1, 1, 0, 8'h11};
    vecs[3] = '{8'h77, 1'b0, 0, 1, 8'h11};
    vecs[4] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    vecs[6] = '{8'h80, 1'b1, 1, 0, 8'h80};
    vecs[7] = '{8'hC3, 1'b1, 1, 0, 8'hC3};
    vecs[8] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
    vecs[9] = '{8'h3C, 1'b0, 0, 1, 8'h5A};

    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(0, 5);

    for (int i = 0; i < 10; i++) begin
      v0 = v_cnt;
      e0 = e_cnt;
      send_frame(0, vecs[i].data, vecs[i].stop, 8, 16, 0);
      idle(0, 20);
      check($sformatf("vec%0d_valid", i), v_cnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_err", i), e_cnt - e0, vecs[i].exp_e);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_d);
    end

    // latency and busy envelope of one frame
    v0 = v_cnt;
    send_frame(0, 8'hA5, 1'b1, 8, 16, 0);
    idle(0, 10);
    lat = v_last - t_start;
    check("t1_one_valid", v_cnt - v0, 1);
    check("t1_latency_154pm1", (lat >= 153 && lat <= 155), 1);
    check("t1_data", data, 8'hA5);
    lows = 0;
    for (int c = t_start + 3; c < v_last; c++) if (!busy_hist[c]) lows++;
    check("t1_busy_high_cycles_low", lows, 0);
    check("t1_busy_low_after", busy_hist[v_last + 1], 0);

    // short low glitch on an idle line
    v0 = v_cnt;
    e0 = e_cnt;
    t_start = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(0, 30);
    highs = 0;
    for (int c = t_start; c < t_start + 20; c++) if (busy_hist[c]) highs++;
    check("t2_busy_pulsed", (highs > 0), 1);
    check("t2_no_valid", v_cnt - v0, 0);
    check("t2_no_err", e_cnt - e0, 0);
    check("t2_idle", busy, 0);
    send_frame(0, 8'h3C, 1'b1, 8, 16, 0);
    idle(0, 20);
    check("t2_follow_valid", v_cnt - v0, 1);
    check("t2_follow_data", data, 8'h3C);

    // framing error followed by a held break
    v0 = v_cnt;
    e0 = e_cnt;
    send_frame(0, 8'h11, 1'b1, 8, 16, 0);
    idle(0, 10);
    send_frame(0, 8'h77, 1'b0, 8, 16, 0);
    repeat (200) @(negedge clk);
    check("t3_err_once", e_cnt - e0, 1);
    check("t3_valid_only_first", v_cnt - v0, 1);
    check("t3_data_kept", data, 8'h11);
    check("t3_busy_in_break", busy, 1);
    idle(0, 20);
    send_frame(0, 8'h3C, 1'b1, 8, 16, 0);
    idle(0, 20);
    check("t3_recover_valid", v_cnt - v0, 2);
    check("t3_recover_data", data, 8'h3C);
    check("t3_err_total", e_cnt - e0, 1);

    // back-to-back frames, one stop bit each
    e0 = e_cnt;
    qi = v_cycs.size();
    send_frame(0, 8'h00, 1'b1, 8, 16, 0);
    send_frame(0, 8'hFF, 1'b1, 8, 16, 0);
    send_frame(0, 8'h80, 1'b1, 8, 16, 0);
    idle(0, 20);
    check("t4_count", v_cycs.size() - qi, 3);
    if (v_cycs.size() - qi >= 3) begin
      check("t4_gap01", v_cycs[qi+1] - v_cycs[qi], 160);
      check("t4_gap12", v_cycs[qi+2] - v_cycs[qi+1], 160);
      check("t4_d0", v_datas[qi], 8'h00);
      check("t4_d1", v_datas[qi+1], 8'hFF);
      check("t4_d2", v_datas[qi+2], 8'h80);
    end
    check("t4_no_err", e_cnt - e0, 0);

    // reset in the middle of data bit 3
    v0 = v_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      rx = b < 2;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    check("t5_rst_data", data, 0);
    check("t5_rst_valid", valid, 0);
    check("t5_rst_err", err, 0);
    check("t5_rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(0, 200);
    check("t5_no_valid_aborted", v_cnt - v0, 0);
    send_frame(0, 8'h5A, 1'b1, 8, 16, 0);
    idle(0, 20);
    check("t5_follow_valid", v_cnt - v0, 1);
    check("t5_follow_data", data, 8'h5A);

    // 5 clk/bit, 5-bit words, nominal and skewed timing
    v0 = v5_cnt;
    send_frame(1, 8'h13, 1'b1, 5, 5, 0);
    idle(1, 10);
    lat = v5_last - t_start;
    check("t6_valid", v5_cnt - v0, 1);
    check("t6_data", data5, 5'h13);
    check("t6_latency_34pm1", (lat >= 33 && lat <= 35), 1);
    send_frame(1, 8'h0D, 1'b1, 5, 5, 1);
    idle(1, 10);
    check("t6_skew_plus_valid", v5_cnt - v0, 2);
    check("t6_skew_plus_data", data5, 5'h0D);
    send_frame(1, 8'h13, 1'b1, 5, 5, -1);
    idle(1, 10);
    check("t6_skew_minus_valid", v5_cnt - v0, 3);
    check("t6_skew_minus_data", data5, 5'h13);
    check("t6_no_err", e5_cnt, 0);

    check("never_valid_and_err", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
